size_field_patcher: RTL and testbench



---
 rtl/size_field_patcher_if.sv | 20 ++
 rtl/size_field_patcher.sv | 135 +++++++++++++
 tb/tb_size_field_patcher.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/size_field_patcher_if.sv
// rtl/size_field_patcher_if.sv - patch request inputs and shared byte write port
interface size_field_patcher_if;
   logic [31:0] offset_addr;
   logic [31:0] val;
   logic [31:0] byte_size;
   logic        mem_ready;
   logic        patch_we;
   logic [31:0] patch_addr;
   logic [7:0]  patch_data;

   modport master (
      output offset_addr, val, byte_size, mem_ready,
      input  patch_we, patch_addr, patch_data
   );

   modport slave (
      input  offset_addr, val, byte_size, mem_ready,
      output patch_we, patch_addr, patch_data
   );
endinterface

// File: rtl/size_field_patcher.sv
// rtl/size_field_patcher.sv - queues size-field patches and writes them big-endian, one byte per grant
module size_field_patcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   size_field_patcher_if.slave bus,
   output logic             busy,
   output logic             overflow,
   output logic             bad_size,
   output logic [CNT_W-1:0] patch_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {IDLE, WRITE} state_t;
   state_t state, next_state;

   logic [31:0]      fifo_addr [FIFO_DEPTH];
   logic [31:0]      fifo_val  [FIFO_DEPTH];
   logic [2:0]       fifo_size [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [OCC_W-1:0] fifo_cnt;
   logic             fifo_empty, fifo_full;
   logic             req_valid, req_bad, push, pop, advance, last_byte;
   logic [2:0]       remaining;
   logic [31:0]      work_val;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [7:0]       data_q;

   // n is the count of bytes still to go; the byte to present is the n-th from the LSB
   function automatic logic [7:0] pick_byte(input logic [31:0] v, input logic [2:0] n);
      logic [31:0] s;
      s = v >> {n - 3'd1, 3'b000};
      return s[7:0];
   endfunction

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == OCC_W'(FIFO_DEPTH));
   assign req_valid  = (bus.byte_size != 32'd0) && (bus.byte_size <= 32'd4);
   assign req_bad    = (bus.byte_size > 32'd4);
   assign push       = req_valid && (!fifo_full || pop);
   assign last_byte  = (state == WRITE) && bus.mem_ready && (remaining == 3'd1);
   assign busy       = !fifo_empty || (state == WRITE);

   assign bus.patch_we   = we_q;
   assign bus.patch_addr = addr_q;
   assign bus.patch_data = data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!fifo_empty) next_state = WRITE;
         WRITE:   if (last_byte && fifo_empty) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      advance = 1'b0;
      case (state)
         IDLE:  pop = !fifo_empty;
         WRITE: begin
            if (bus.mem_ready) begin
               if (remaining == 3'd1) pop = !fifo_empty;
               else                   advance = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.offset_addr;
         fifo_val[wr_ptr]  <= bus.val;
         fifo_size[wr_ptr] <= bus.byte_size[2:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         overflow <= 1'b0;
         bad_size <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + OCC_W'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - OCC_W'(1);
         if (req_valid && !push) overflow <= 1'b1;
         if (req_bad)            bad_size <= 1'b1;
      end
   end

   // a pop on the last byte's grant chains straight into the next field with no gap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         remaining   <= '0;
         work_val    <= '0;
         patch_count <= '0;
      end else begin
         if (last_byte) patch_count <= patch_count + CNT_W'(1);
         if (pop) begin
            we_q      <= 1'b1;
            addr_q    <= fifo_addr[rd_ptr];
            data_q    <= pick_byte(fifo_val[rd_ptr], fifo_size[rd_ptr]);
            remaining <= fifo_size[rd_ptr];
            work_val  <= fifo_val[rd_ptr];
         end else if (advance) begin
            addr_q    <= addr_q + 32'd1;
            data_q    <= pick_byte(work_val, remaining - 3'd1);
            remaining <= remaining - 3'd1;
         end else if (last_byte) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            remaining <= '0;
         end
      end
   end
endmodule

// File: tb/tb_size_field_patcher.sv
// tb/tb_size_field_patcher.sv - randomized bench for size_field_patcher against a queue-based byte model
module tb_size_field_patcher;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] val;
      int          size;
   } req_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } byte_t;

   logic        clock;
   logic        reset_n;
   logic        busy;
   logic        overflow;
   logic        bad_size;
   logic [15:0] patch_count;

   size_field_patcher_if bus ();

   size_field_patcher dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .busy        (busy),
      .overflow    (overflow),
      .bad_size    (bad_size),
      .patch_count (patch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_vec;
   int          n_err;
   req_t        fifo_q[$];
   byte_t       cur[$];
   logic [15:0] exp_count;
   logic        exp_ovf;
   logic        exp_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete();
      cur.delete();
      exp_count = '0;
      exp_ovf   = 1'b0;
      exp_bad   = 1'b0;
   endtask

   // One clock edge of the reference: a granted byte leaves the stream, an empty stream
   // takes the oldest queued field, then the current request is queued if there is room.
   task automatic model_edge();
      req_t  r;
      byte_t b;
      int    sz;
      if (cur.size() != 0 && bus.mem_ready) begin
         if (cur.size() == 1) exp_count = exp_count + 16'd1;
         cur.delete(0);
      end
      if (cur.size() == 0 && fifo_q.size() != 0) begin
         r = fifo_q.pop_front();
         for (int i = 0; i < r.size; i++) begin
            b.addr = r.addr + 32'(i);
            b.data = 8'(r.val >> (8 * (r.size - 1 - i)));
            cur.push_back(b);
         end
      end
      sz = (bus.byte_size > 32'd4) ? 5 : int'(bus.byte_size);
      if (sz > 4) exp_bad = 1'b1;
      else if (sz != 0) begin
         if (fifo_q.size() < DEPTH) begin
            r.addr = bus.offset_addr;
            r.val  = bus.val;
            r.size = sz;
            fifo_q.push_back(r);
         end else begin
            exp_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      check("patch_we",   {31'd0, bus.patch_we}, {31'd0, cur.size() != 0});
      check("patch_addr", bus.patch_addr, (cur.size() != 0) ? cur[0].addr : 32'd0);
      check("patch_data", {24'd0, bus.patch_data}, {24'd0, (cur.size() != 0) ? cur[0].data : 8'd0});
      check("busy",       {31'd0, busy}, {31'd0, (cur.size() != 0) || (fifo_q.size() != 0)});
      check("overflow",   {31'd0, overflow}, {31'd0, exp_ovf});
      check("bad_size",   {31'd0, bad_size}, {31'd0, exp_bad});
      check("patch_count", {16'd0, patch_count}, {16'd0, exp_count});
   endtask

   task automatic cycle(input logic [31:0] a, input logic [31:0] v, input logic [31:0] s,
                        input logic rdy);
      bus.offset_addr = a;
      bus.val         = v;
      bus.byte_size   = s;
      bus.mem_ready   = rdy;
      model_edge();
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic drain();
      int budget;
      budget = 60;
      while ((cur.size() != 0 || fifo_q.size() != 0) && budget > 0) begin
         cycle(32'd0, 32'd0, 32'd0, 1'b1);
         budget--;
      end
      if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
      cycle(32'd0, 32'd0, 32'd0, 1'b1);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_we",    {31'd0, bus.patch_we}, 32'd0);
      check("rst_addr",  bus.patch_addr, 32'd0);
      check("rst_data",  {24'd0, bus.patch_data}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_ovf",   {31'd0, overflow}, 32'd0);
      check("rst_bad",   {31'd0, bad_size}, 32'd0);
      check("rst_count", {16'd0, patch_count}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] a, v, s;
      logic        rdy;
      n_vec = 0;
      n_err = 0;
      bus.offset_addr = '0;
      bus.val         = '0;
      bus.byte_size   = '0;
      bus.mem_ready   = 1'b0;
      reset_n         = 1'b1;
      #2;
      apply_reset();

      cycle(32'h100, 32'h1234, 32'd2, 1'b1);
      drain();

      cycle(32'h20, 32'hA1B2C3D4, 32'd4, 1'b1);
      cycle(32'd0, 32'd0, 32'd0, 1'b1);
      cycle(32'd0, 32'd0, 32'd0, 1'b1);
      repeat (3) cycle(32'd0, 32'd0, 32'd0, 1'b0);
      drain();

      cycle(32'h10, 32'h0300, 32'd2, 1'b1);
      cycle(32'h04, 32'h1000, 32'd4, 1'b1);
      cycle(32'h00, 32'h2000, 32'd4, 1'b1);
      cycle(32'h40, 32'h0111, 32'd2, 1'b1);
      cycle(32'h42, 32'h0222, 32'd2, 1'b1);
      drain();

      for (int i = 0; i < 6; i++)
         cycle(32'h200 + 32'(i * 8), 32'h11223344 + 32'(i), 32'(1 + (i % 4)), 1'b0);
      repeat (2) cycle(32'd0, 32'd0, 32'd0, 1'b0);
      drain();

      cycle(32'h9, 32'hDEAD, 32'd5, 1'b1);
      cycle(32'h7, 32'h1FF, 32'd1, 1'b1);
      drain();

      apply_reset();
      cycle(32'h300, 32'hCAFEF00D, 32'd4, 1'b1);
      cycle(32'd0, 32'd0, 32'd0, 1'b1);
      cycle(32'd0, 32'd0, 32'd0, 1'b1);
      apply_reset();
      repeat (4) cycle(32'd0, 32'd0, 32'd0, 1'b1);

      cycle(32'hFFFF_FFFE, 32'h0A0B0C0D, 32'd4, 1'b1);
      drain();

      for (int i = 0; i < 3000; i++) begin
         a   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD : $urandom;
         v   = $urandom;
         case ($urandom_range(0, 19))
            0:                 s = 32'd5 + 32'($urandom_range(0, 1000));
            1, 2, 3, 4, 5, 6,
            7, 8, 9:           s = 32'($urandom_range(1, 4));
            default:           s = 32'd0;
         endcase
         rdy = ($urandom_range(0, 9) < 7);
         cycle(a, v, s, rdy);
         if (i % 500 == 499) begin
            drain();
            apply_reset();
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
